// File: rtl/pla_sweep_pkg.sv
// Shared types and sizing for the PLA exhaustive-sweep sequencer.
package pla_sweep_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_SAMPLE,
    ST_EMIT,
    ST_DONE
  } state_t;

  localparam int N_IN_DEF   = 8;
  localparam int W_DEF      = 16;
  localparam int SETTLE_DEF = 1;
  localparam int NVEC       = 2 ** N_IN_DEF;
  localparam int WORDS      = NVEC / W_DEF;

  // A one-cycle settle still needs a 1-bit counter register.
  function automatic int settle_cnt_w(input int settle);
    return (settle < 2) ? 1 : $clog2(settle + 1);
  endfunction

  localparam int SCNT_W = settle_cnt_w(SETTLE_DEF);

endpackage

// File: rtl/pla_sweep_ctrl_tt_packer.sv
// Truth-table word assembly: bit-insert accumulator plus the output word
// register that is held under valid/ready until the consumer takes it.
module pla_sweep_ctrl_tt_packer #(
  parameter int W     = 16,
  parameter int IDX_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             ins_en,
  input  logic             ins_last,
  input  logic [IDX_W-1:0] ins_idx,
  input  logic             ins_bit,
  input  logic             flush,
  input  logic             tt_ready,
  output logic [W-1:0]     tt_word,
  output logic             tt_valid
);

  logic [W-1:0] acc;
  logic [W-1:0] acc_nx;

  always_comb begin
    acc_nx          = acc;
    acc_nx[ins_idx] = ins_bit;
  end

  // Handshake: a word transfers on any rising edge with tt_valid & tt_ready;
  // tt_word never changes while tt_valid is high and not yet accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc      <= '0;
      tt_word  <= '0;
      tt_valid <= 1'b0;
    end else begin
      if (clear) begin
        acc <= '0;
      end else if (ins_en) begin
        acc <= acc_nx;
      end
      if (ins_en && ins_last) begin
        tt_word <= acc_nx;
      end
      if (flush) begin
        tt_valid <= 1'b0;
      end else if (ins_en && ins_last) begin
        tt_valid <= 1'b1;
      end else if (tt_valid && tt_ready) begin
        tt_valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/pla_sweep_ctrl.sv
// Drives every input vector into two PLA implementations, streams A's truth
// table out in W-bit words and reports A's onset count and A/B equivalence.
module pla_sweep_ctrl
  import pla_sweep_pkg::*;
#(
  parameter int N_IN   = N_IN_DEF,
  parameter int W      = W_DEF,
  parameter int SETTLE = SETTLE_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            abort,
  output logic [N_IN-1:0] x_o,
  input  logic            ya_i,
  input  logic            yb_i,
  output logic [W-1:0]    tt_word,
  output logic            tt_valid,
  input  logic            tt_ready,
  output logic            busy,
  output logic            done,
  output logic            equal,
  output logic [N_IN-1:0] mismatch_vec,
  output logic [N_IN:0]   onset,
  output state_t          state_dbg
);

  localparam int CNT_W = settle_cnt_w(SETTLE);
  localparam int IDX_W = (W > 1) ? $clog2(W) : 1;
  localparam logic [N_IN-1:0]  VEC_LAST = '1;
  localparam logic [N_IN-1:0]  WMASK    = N_IN'(W - 1);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(SETTLE - 1);

  state_t            state, state_nx;
  logic [N_IN-1:0]   vec;
  logic [CNT_W-1:0]  settle_cnt;
  logic              mm_flag;
  logic              start_acc, do_sample, abort_now;
  logic              word_last, emit_hs;

  assign word_last = (vec & WMASK) == WMASK;
  assign emit_hs   = tt_valid & tt_ready;
  assign state_dbg = state;

  always_comb begin
    state_nx  = state;
    start_acc = 1'b0;
    do_sample = 1'b0;
    abort_now = 1'b0;
    if (state != ST_IDLE && abort) begin
      state_nx  = ST_IDLE;
      abort_now = 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start && !abort) begin
            state_nx  = ST_SETTLE;
            start_acc = 1'b1;
          end
        end
        ST_SETTLE: if (settle_cnt == '0) state_nx = ST_SAMPLE;
        ST_SAMPLE: begin
          do_sample = 1'b1;
          state_nx  = word_last ? ST_EMIT : ST_SETTLE;
        end
        ST_EMIT: if (emit_hs) state_nx = (vec == VEC_LAST) ? ST_DONE : ST_SETTLE;
        ST_DONE: state_nx = ST_IDLE;
        default: state_nx = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      vec          <= '0;
      settle_cnt   <= '0;
      mm_flag      <= 1'b0;
      x_o          <= '0;
      onset        <= '0;
      mismatch_vec <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      equal        <= 1'b0;
    end else begin
      state <= state_nx;
      busy  <= (state_nx != ST_IDLE);
      done  <= (state_nx == ST_DONE);
      if (start_acc) begin
        vec          <= '0;
        x_o          <= '0;
        settle_cnt   <= CNT_INIT;
        onset        <= '0;
        mm_flag      <= 1'b0;
        mismatch_vec <= '0;
        equal        <= 1'b0;
      end
      if (abort_now) begin
        x_o   <= '0;
        equal <= 1'b0;
      end
      if (state == ST_SETTLE && settle_cnt != '0 && !abort_now) begin
        settle_cnt <= settle_cnt - CNT_W'(1);
      end
      if (do_sample) begin
        onset <= onset + (N_IN + 1)'(ya_i);
        if (ya_i != yb_i && !mm_flag) begin
          mm_flag      <= 1'b1;
          mismatch_vec <= vec;
        end
      end
      // Advancing to the next vector happens from SAMPLE or after a word is taken.
      if (state_nx == ST_SETTLE && (state == ST_SAMPLE || state == ST_EMIT)) begin
        vec        <= vec + N_IN'(1);
        x_o        <= vec + N_IN'(1);
        settle_cnt <= CNT_INIT;
      end
      if (state == ST_EMIT && state_nx == ST_DONE) begin
        equal <= !mm_flag;
      end
    end
  end

  pla_sweep_ctrl_tt_packer #(
    .W     (W),
    .IDX_W (IDX_W)
  ) u_packer (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (start_acc),
    .ins_en   (do_sample),
    .ins_last (word_last),
    .ins_idx  (IDX_W'(vec & WMASK)),
    .ins_bit  (ya_i),
    .flush    (abort_now),
    .tt_ready (tt_ready),
    .tt_word  (tt_word),
    .tt_valid (tt_valid)
  );

endmodule
